// File: rtl/dht11_read_scheduler.sv
// -----------------------------------------------------------------------------
// dht11_read_scheduler
//
// Sits between the host command decoder and a DHT11 single-wire reader, on the
// reader's clock. Accepts one read request at a time, spaces start strobes by
// at least MIN_GAP_CYC cycles, holds the reader's start strobe for START_HOLD
// cycles, waits up to TIMEOUT_CYC cycles for the reader's done pulse, retries
// up to MAX_RETRY extra times on checksum error or timeout, and then returns a
// single response carrying the last captured frame and a status code.
//
// Ports
//   clk        in   clock (same clock as the reader)
//   rst        in   asynchronous, active-high reset
//   req        in   host read request (level, sampled only while req_ready=1)
//   req_ready  out  high while idle and able to take a request
//   busy       out  inverse of req_ready
//   rsp_valid  out  one-cycle response strobe
//   rsp_status out  00 ok, 01 checksum error, 10 timeout (held between responses)
//   rsp_data   out  last captured frame {hum_i, hum_d, temp_i, temp_d, sum}
//   dht_start  out  start strobe to the reader
//   dht_done   in   reader completion pulse (one cycle)
//   dht_error  in   reader checksum-mismatch flag, valid with dht_done
//   dht_data   in   reader frame, valid with dht_done
// -----------------------------------------------------------------------------
module dht11_read_scheduler #(
   parameter int MIN_GAP_CYC = 2_000_000,
   parameter int TIMEOUT_CYC = 100_000,
   parameter int START_HOLD  = 4,
   parameter int MAX_RETRY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   output logic        req_ready,
   output logic        busy,
   output logic        rsp_valid,
   output logic [1:0]  rsp_status,
   output logic [39:0] rsp_data,
   output logic        dht_start,
   input  logic        dht_done,
   input  logic        dht_error,
   input  logic [39:0] dht_data
);

   localparam int GAP_W  = $clog2(MIN_GAP_CYC + 1);
   localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
   localparam int HOLD_W = $clog2(START_HOLD + 1);
   localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(MIN_GAP_CYC);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
   localparam logic [RTRY_W-1:0] RTRY_MAX  = RTRY_W'(MAX_RETRY);

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_CRC = 2'b01;
   localparam logic [1:0] ST_TMO = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GAP   = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_EVAL  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [RTRY_W-1:0]   retry_cnt_q, retry_cnt_d;
   logic                err_q, err_d;
   logic                tmo_q, tmo_d;
   logic [1:0]          rsp_status_q, rsp_status_d;
   logic [39:0]         rsp_data_q, rsp_data_d;
   logic                dht_start_q, dht_start_d;
   logic                rsp_valid_q, rsp_valid_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         gap_cnt_q    <= '0;
         hold_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         retry_cnt_q  <= '0;
         err_q        <= 1'b0;
         tmo_q        <= 1'b0;
         rsp_status_q <= ST_OK;
         rsp_data_q   <= '0;
         dht_start_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_cnt_q    <= gap_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         retry_cnt_q  <= retry_cnt_d;
         err_q        <= err_d;
         tmo_q        <= tmo_d;
         rsp_status_q <= rsp_status_d;
         rsp_data_q   <= rsp_data_d;
         dht_start_q  <= dht_start_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      retry_cnt_d  = retry_cnt_q;
      err_d        = err_q;
      tmo_d        = tmo_q;
      rsp_status_d = rsp_status_q;
      rsp_data_d   = rsp_data_q;

      // Gap counter runs in every state and saturates; it starts from zero
      // out of reset so the sensor also gets its power-up settle time.
      if (gap_cnt_q != GAP_MAX) begin
         gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end else begin
         gap_cnt_d = gap_cnt_q;
      end

      case (state_q)
         S_IDLE: begin
            if (req) begin
               retry_cnt_d = '0;
               state_d     = S_GAP;
            end
         end

         S_GAP: begin
            if (gap_cnt_q >= GAP_MAX) begin
               gap_cnt_d  = '0;
               hold_cnt_d = '0;
               state_d    = S_START;
            end
         end

         S_START: begin
            // Held at zero for the whole strobe so the gap is measured from
            // the end of the strobe: rising edges end up at least
            // MIN_GAP_CYC + START_HOLD cycles apart.
            gap_cnt_d = '0;
            if (hold_cnt_q == HOLD_LAST) begin
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end

         S_WAIT: begin
            // A done pulse in the last timeout cycle still counts as done.
            if (dht_done) begin
               rsp_data_d = dht_data;
               err_d      = dht_error;
               tmo_d      = 1'b0;
               state_d    = S_EVAL;
            end else if (wait_cnt_q == WAIT_LAST) begin
               err_d   = 1'b0;
               tmo_d   = 1'b1;
               state_d = S_EVAL;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end

         S_EVAL: begin
            if (!err_q && !tmo_q) begin
               rsp_status_d = ST_OK;
               state_d      = S_RESP;
            end else if (retry_cnt_q < RTRY_MAX) begin
               retry_cnt_d = retry_cnt_q + RTRY_W'(1);
               state_d     = S_GAP;
            end else begin
               rsp_status_d = tmo_q ? ST_TMO : ST_CRC;
               state_d      = S_RESP;
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Strobes are registered decodes of the next state so they line up
      // exactly with the START and RESP state cycles.
      dht_start_d = (state_d == S_START);
      rsp_valid_d = (state_d == S_RESP);
   end

   assign req_ready  = (state_q == S_IDLE);
   assign busy       = ~req_ready;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_status = rsp_status_q;
   assign rsp_data   = rsp_data_q;
   assign dht_start  = dht_start_q;

endmodule
